// File: rtl/conv_encoder_stream.sv
// ---------------------------------------------------------------------------
// conv_encoder_stream
//   Rate-1/2 convolutional encoder with a built-in serializer. It latches a
//   MSG_LEN-bit message when i_start rises and sends one 2-bit coded symbol
//   per clock, MSB first. Optionally K-1 zero tail bits follow, which flush
//   the trellis back to state 0.
//
// Ports
//   i_clk        in   1        rising-edge clock
//   i_rst_n      in   1        asynchronous active-low reset
//   i_start      in   1        level input; a rising edge in IDLE starts a frame
//   i_data       in   MSG_LEN  message, sampled only on the accepted start edge
//   o_data       out  2        coded symbol {G0 parity, G1 parity}
//   o_valid      out  1        o_data holds a valid symbol this cycle
//   o_busy       out  1        frame in progress (ENC or TAIL)
//   o_done       out  1        one-cycle pulse after the last symbol
//   o_dbg_state  out  2        current FSM state (IDLE=0, ENC=1, TAIL=2, DONE=3)
//
// Handshake: o_valid is a pure strobe with no ready. The consumer must take
// o_data in every cycle where o_valid=1. The symbols of a frame form one
// unbroken run.
// ---------------------------------------------------------------------------
module conv_encoder_stream #(
    parameter int           MSG_LEN = 8,
    parameter int           K       = 3,
    parameter logic [K-1:0] G0      = 3'b111,
    parameter logic [K-1:0] G1      = 3'b101,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [MSG_LEN-1:0] i_data,
    output logic [1:0]         o_data,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, TAIL = 2'd2, DONE = 2'd3} state_t;

    localparam int CW = $clog2(MSG_LEN + K);

    state_t             state;
    logic [CW-1:0]      idx;
    logic [MSG_LEN-1:0] msg;
    logic [K-2:0]       sr;
    logic               start_q;
    logic               start_edge;
    logic               u_cur;
    logic [K-2:0]       sr_cur;

    // Parity of the tapped bits. v = {u, sr}, and sr[K-2] is the most recent bit.
    function automatic logic [1:0] encode(input logic u, input logic [K-2:0] s);
        logic [K-1:0] v;
        v = {u, s};
        return {^(v & G0), ^(v & G1)};
    endfunction

    // Shift the new bit in at the top. The oldest bit falls off sr[0].
    function automatic logic [K-2:0] shift_in(input logic u, input logic [K-2:0] s);
        logic [K-2:0] n;
        n = s >> 1;
        n[K-2] = u;
        return n;
    endfunction

    assign start_edge  = i_start & ~start_q;
    assign o_dbg_state = state;

    // This is the bit encoded at the coming edge. In IDLE it is the message MSB.
    // The first symbol must appear in the cycle right after the start edge.
    // In that case the encoder starts from a cleared register.
    always_comb begin
        u_cur  = 1'b0;
        sr_cur = sr;
        case (state)
            IDLE: begin
                u_cur  = i_data[MSG_LEN-1];
                sr_cur = '0;
            end
            ENC:     u_cur = (idx != CW'(MSG_LEN)) ? msg[MSG_LEN-1] : 1'b0;
            default: u_cur = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            msg     <= '0;
            sr      <= '0;
            start_q <= 1'b1;   // a switch already high at reset release is not an edge
            o_data  <= 2'b00;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            start_q <= i_start;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        o_data  <= encode(u_cur, sr_cur);
                        sr      <= shift_in(u_cur, sr_cur);
                        msg     <= i_data << 1;   // MSB already consumed this edge
                        idx     <= CW'(1);
                        o_valid <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= ENC;
                    end
                end
                ENC: begin
                    if (idx != CW'(MSG_LEN)) begin
                        o_data <= encode(u_cur, sr_cur);
                        sr     <= shift_in(u_cur, sr_cur);
                        msg    <= msg << 1;
                        idx    <= idx + CW'(1);
                    end else if (TAIL_EN) begin
                        // The first tail symbol goes out here, so TAIL counts from 1.
                        o_data <= encode(1'b0, sr_cur);
                        sr     <= shift_in(1'b0, sr_cur);
                        idx    <= CW'(1);
                        state  <= TAIL;
                    end else begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= DONE;
                    end
                end
                TAIL: begin
                    if (idx != CW'(K - 1)) begin
                        o_data <= encode(1'b0, sr_cur);
                        sr     <= shift_in(1'b0, sr_cur);
                        idx    <= idx + CW'(1);
                    end else begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_stream
//   Testbench for conv_encoder_stream. dut_a appends the tail and dut_b does
//   not. Both share their inputs. Expected symbols come from a convolution
//   model of the generator taps or from fixed known-answer lists. A small
//   hard-decision Viterbi decoder provides the loopback check.
// ---------------------------------------------------------------------------
module tb_conv_encoder_stream;

    localparam int MSG_LEN = 8;
    localparam int K       = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_start;
    logic [MSG_LEN-1:0] i_data;

    logic [1:0] a_data, b_data, a_state, b_state;
    logic       a_valid, a_busy, a_done;
    logic       b_valid, b_busy, b_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];
    logic [1:0] cap[16];
    int         cap_n;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, run did not finish");
        $fatal(1, "watchdog");
    end

    conv_encoder_stream #(.MSG_LEN(MSG_LEN), .K(K), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_data(i_data),
        .o_data(a_data), .o_valid(a_valid), .o_busy(a_busy), .o_done(a_done),
        .o_dbg_state(a_state)
    );

    conv_encoder_stream #(.MSG_LEN(MSG_LEN), .K(K), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_data(i_data),
        .o_data(b_data), .o_valid(b_valid), .o_busy(b_busy), .o_done(b_done),
        .o_dbg_state(b_state)
    );

    // ---------------- reference model ----------------
    // Output j is a parity over the input bits b[j-d], d = 0..K-1. Each term
    // is weighted by generator bit K-1-d. Bits before the message and tail
    // bits are zero.
    function automatic void model_push(input logic [7:0] data, input bit tail);
        logic [2:0] g0;
        logic [2:0] g1;
        logic       p0, p1, b;
        int         n, i;
        g0 = 3'b111;
        g1 = 3'b101;
        n  = MSG_LEN + (tail ? K - 1 : 0);
        for (int j = 0; j < n; j++) begin
            p0 = 1'b0;
            p1 = 1'b0;
            for (int d = 0; d < K; d++) begin
                i  = j - d;
                b  = (i >= 0 && i < MSG_LEN) ? data[MSG_LEN-1-i] : 1'b0;
                p0 = p0 ^ (g0[K-1-d] & b);
                p1 = p1 ^ (g1[K-1-d] & b);
            end
            exp_q.push_back({p0, p1});
        end
    endfunction

    // Hard-decision Viterbi decoder. It ends in state 0 because of the tail.
    function automatic logic [7:0] viterbi(input logic [1:0] s[16], input int n);
        int          pm[4];
        int          npm[4];
        logic [15:0] sv[4];
        logic [15:0] nsv[4];
        logic [2:0]  v;
        logic [1:0]  sym, st, ns;
        int          m;
        pm = '{0, 1000, 1000, 1000};
        sv = '{16'h0, 16'h0, 16'h0, 16'h0};
        for (int t = 0; t < n; t++) begin
            npm = '{1000000, 1000000, 1000000, 1000000};
            nsv = sv;
            for (int si = 0; si < 4; si++) begin
                for (int u = 0; u < 2; u++) begin
                    st  = 2'(si);
                    v   = {u[0], st};
                    sym = {^(v & 3'b111), ^(v & 3'b101)};
                    ns  = {u[0], st[1]};
                    m   = pm[si] + int'(sym[1] != s[t][1]) + int'(sym[0] != s[t][0]);
                    if (m < npm[ns]) begin
                        npm[ns] = m;
                        nsv[ns] = {sv[si][14:0], u[0]};
                    end
                end
            end
            pm = npm;
            sv = nsv;
        end
        return 8'(sv[0] >> (K - 1));
    endfunction

    // ---------------- driver / checker ----------------
    // The caller fills exp_q. This task raises i_start and checks the control
    // outputs in every cycle. It pops one symbol per valid cycle and records
    // it in cap[].
    task automatic check_frame(input logic [7:0] data, input bit sel_b,
                               input bit mid_toggle, input string name);
        int         n;
        logic       v, bz, dn;
        logic [1:0] d, e;
        logic [2:0] exp_ctl;
        n     = exp_q.size();
        cap_n = 0;
        @(posedge clk);
        #1;
        i_data  = data;
        i_start = 1'b1;
        for (int c = 0; c <= n + 2; c++) begin
            @(negedge clk);
            if (sel_b) {v, bz, dn, d} = {b_valid, b_busy, b_done, b_data};
            else       {v, bz, dn, d} = {a_valid, a_busy, a_done, a_data};
            if (c == 1) i_data = 8'($urandom);   // a later change must not be seen
            if (mid_toggle && c == 3) i_start = 1'b0;
            if (mid_toggle && c == 5) i_start = 1'b1;
            if (c >= 1 && c <= n) exp_ctl = 3'b110;
            else if (c == n + 1)  exp_ctl = 3'b001;
            else                  exp_ctl = 3'b000;
            n_cmp++;
            if ({v, bz, dn} !== exp_ctl) begin
                n_err++;
                $display("FAIL %s ctl cycle %0d: valid/busy/done got %b want %b",
                         name, c, {v, bz, dn}, exp_ctl);
            end
            if (c >= 1 && c <= n) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (d !== e) begin
                    n_err++;
                    $display("FAIL %s symbol %0d: got %b want %b", name, c - 1, d, e);
                end
                cap[cap_n] = d;
                cap_n++;
            end
        end
        if (!mid_toggle) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_valid, a_busy, a_done, b_valid, b_busy, b_done} !== 6'b0) begin
                n_err++;
                $display("FAIL %s cycle %0d: a vbd %b b vbd %b want 000 000", name, c,
                         {a_valid, a_busy, a_done}, {b_valid, b_busy, b_done});
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        i_start = 1'b1;
        i_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_data, a_valid, a_busy, a_done, a_state, b_data, b_valid, b_busy, b_done} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_values: got a=%b/%b%b%b st=%0d b=%b/%b%b%b want all 0",
                     a_data, a_valid, a_busy, a_done, a_state, b_data, b_valid, b_busy, b_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("reset_switch_high", 5);
        i_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_known_b0();
        logic [1:0] k[10];
        k = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        foreach (k[i]) exp_q.push_back(k[i]);
        check_frame(8'hB0, 1'b0, 1'b0, "b0_tail");
    endtask

    task automatic test_known_ff();
        logic [1:0] k[10];
        k = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
        foreach (k[i]) exp_q.push_back(k[i]);
        check_frame(8'hFF, 1'b0, 1'b0, "ff_tail");
        // The tail must have flushed the encoder: an all-zero frame is all 00.
        repeat (10) exp_q.push_back(2'b00);
        check_frame(8'h00, 1'b0, 1'b0, "zero_after_ff");
    endtask

    task automatic test_no_tail();
        logic [1:0] k[8];
        k = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
        foreach (k[i]) exp_q.push_back(k[i]);
        check_frame(8'hB0, 1'b1, 1'b0, "b0_notail");
    endtask

    task automatic test_hold_high();
        logic [7:0] d;
        d = 8'($urandom);
        model_push(d, 1'b1);
        check_frame(d, 1'b0, 1'b1, "hold_high");
        check_idle("hold_no_retrigger", 12);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(posedge clk);
        d = 8'($urandom);
        model_push(d, 1'b1);
        check_frame(d, 1'b0, 1'b0, "after_hold");
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        logic [1:0] e;
        d = 8'($urandom);
        model_push(d, 1'b1);
        @(posedge clk);
        #1;
        i_data  = d;
        i_start = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({a_valid, a_data} !== {1'b1, e}) begin
                    n_err++;
                    $display("FAIL abort_pre symbol %0d: got v=%b d=%b want v=1 d=%b",
                             c - 1, a_valid, a_data, e);
                end
            end
        end
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_data, a_valid, a_busy, a_done} !== 5'b0) begin
            n_err++;
            $display("FAIL abort_async: got d=%b v=%b b=%b done=%b want all 0",
                     a_data, a_valid, a_busy, a_done);
        end
        check_idle("abort_in_reset", 3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("abort_no_done", 4);
        i_start = 1'b0;
        @(posedge clk);
        repeat (10) exp_q.push_back(2'b00);
        check_frame(8'h00, 1'b0, 1'b0, "restart_zero");
    endtask

    task automatic test_loopback();
        logic [7:0] d, dec;
        for (int f = 0; f < 200; f++) begin
            d = 8'($urandom);
            model_push(d, 1'b1);
            check_frame(d, 1'b0, 1'b0, "loop");
            dec = viterbi(cap, cap_n);
            n_cmp++;
            if (dec !== d) begin
                n_err++;
                $display("FAIL loop_decode frame %0d: got %h want %h", f, dec, d);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_known_b0();
        test_known_ff();
        test_no_tail();
        test_hold_high();
        test_reset_abort();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
